prt_vtb_cm: RTL and testbench



---
 rtl/prt_vtb_cm.sv | 222 ++++++++++++++++++++++
 tb/tb_prt_vtb_cm.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prt_vtb_cm.sv
// -----------------------------------------------------------------------------
// prt_vtb_cm - video toolbox clock enable meter
//
// Counts CKE_IN pulses over back-to-back gate windows of G CLK_IN cycles and
// publishes each result on the status port. Each result is also sent as a
// high/low 16-bit word pair on the VPS write interface, so a toolbox clock
// generator can reproduce the measured rate.
//
// Ports:
//   CLK_IN       clock
//   RST_IN       synchronous active-high reset
//   CTL_RUN_IN   run enable; low = idle and clear measurement state
//   CTL_GATE_IN  gate window length G in CLK_IN cycles (0 = no window, 1 -> 2)
//   CKE_IN       clock enable being measured
//   STA_CNT_OUT  last measured pulse count
//   STA_OF_OUT   last measurement saturated
//   STA_VLD_OUT  one-cycle pulse when a new result is presented
//   VPS_IDX_OUT  VPS register index (P_VPS_IDX for high word, +1 for low word)
//   VPS_DAT_OUT  VPS data word
//   VPS_VLD_OUT  VPS write strobe
// -----------------------------------------------------------------------------
module prt_vtb_cm #(
   parameter int unsigned P_VPS_IDX = 2
) (
   input  logic        CLK_IN,
   input  logic        RST_IN,
   input  logic        CTL_RUN_IN,
   input  logic [31:0] CTL_GATE_IN,
   input  logic        CKE_IN,
   output logic [31:0] STA_CNT_OUT,
   output logic        STA_OF_OUT,
   output logic        STA_VLD_OUT,
   output logic [3:0]  VPS_IDX_OUT,
   output logic [15:0] VPS_DAT_OUT,
   output logic        VPS_VLD_OUT
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HI   = 2'd1,
      ST_LO   = 2'd2
   } tx_st_t;

   // Low-word index wraps mod 16 by truncation to the 4-bit index width.
   localparam logic [3:0] LP_IDX_HI = 4'(P_VPS_IDX);
   localparam logic [3:0] LP_IDX_LO = 4'(P_VPS_IDX + 32'd1);

   logic        r_run_q;
   logic        r_active;     // a window is open and past its first cycle
   logic [31:0] r_gate_cnt;   // gate count of the current cycle (0 = last)
   logic [31:0] r_pulse_cnt;
   logic        r_of;
   tx_st_t      r_tx_st;
   logic [31:0] r_sta_cnt;
   logic        r_sta_of;
   logic        r_sta_vld;
   logic [3:0]  r_vps_idx;
   logic [15:0] r_vps_dat;
   logic        r_vps_vld;

   logic        w_first;
   logic        w_last;
   logic [31:0] w_gate_eff;
   logic [31:0] w_base;
   logic        w_of_base;
   logic [31:0] w_pulse_nxt;
   logic        w_of_nxt;
   tx_st_t      w_tx_nxt;

   // Window control and saturating pulse accumulation for the current cycle.
   always_comb begin
      w_first     = 1'b0;
      w_last      = 1'b0;
      w_gate_eff  = CTL_GATE_IN;
      w_base      = 32'd0;
      w_of_base   = 1'b0;
      w_pulse_nxt = 32'd0;
      w_of_nxt    = 1'b0;
      if (CTL_GATE_IN == 32'd1) begin
         w_gate_eff = 32'd2;
      end else begin
         w_gate_eff = CTL_GATE_IN;
      end
      // The first window cycle is any run cycle with no open window; G=0
      // keeps it from opening, so the gate is re-sampled every cycle.
      w_first = r_run_q & ~r_active & (CTL_GATE_IN != 32'd0);
      w_last  = r_run_q & r_active & (r_gate_cnt == 32'd0);
      // A fresh window starts its count from zero in its first cycle.
      if (r_active) begin
         w_base    = r_pulse_cnt;
         w_of_base = r_of;
      end else begin
         w_base    = 32'd0;
         w_of_base = 1'b0;
      end
      if (CKE_IN) begin
         if (w_base == 32'hFFFF_FFFF) begin
            w_pulse_nxt = w_base;
            w_of_nxt    = 1'b1;
         end else begin
            w_pulse_nxt = w_base + 32'd1;
            w_of_nxt    = w_of_base;
         end
      end else begin
         w_pulse_nxt = w_base;
         w_of_nxt    = w_of_base;
      end
   end

   // Registered copy of the run control.
   always_ff @(posedge CLK_IN) begin
      if (RST_IN) begin
         r_run_q <= 1'b0;
      end else begin
         r_run_q <= CTL_RUN_IN;
      end
   end

   // Gate down-counter and pulse counter; windows follow each other with no gap.
   always_ff @(posedge CLK_IN) begin
      if (RST_IN || !r_run_q) begin
         r_active    <= 1'b0;
         r_gate_cnt  <= 32'd0;
         r_pulse_cnt <= 32'd0;
         r_of        <= 1'b0;
      end else if (w_first) begin
         // First cycle implicitly has count G-1; the next cycle holds G-2.
         r_active    <= 1'b1;
         r_gate_cnt  <= w_gate_eff - 32'd2;
         r_pulse_cnt <= w_pulse_nxt;
         r_of        <= w_of_nxt;
      end else if (w_last) begin
         // Closing the window makes the next cycle the first of a new one.
         r_active    <= 1'b0;
         r_gate_cnt  <= 32'd0;
         r_pulse_cnt <= 32'd0;
         r_of        <= 1'b0;
      end else if (r_active) begin
         r_gate_cnt  <= r_gate_cnt - 32'd1;
         r_pulse_cnt <= w_pulse_nxt;
         r_of        <= w_of_nxt;
      end else begin
         r_active    <= 1'b0;
         r_gate_cnt  <= 32'd0;
         r_pulse_cnt <= 32'd0;
         r_of        <= 1'b0;
      end
   end

   // Status outputs: result registered one cycle after the last window cycle.
   always_ff @(posedge CLK_IN) begin
      if (RST_IN) begin
         r_sta_cnt <= 32'd0;
         r_sta_of  <= 1'b0;
         r_sta_vld <= 1'b0;
      end else if (w_last) begin
         r_sta_cnt <= w_pulse_nxt;
         r_sta_of  <= w_of_nxt;
         r_sta_vld <= 1'b1;
      end else begin
         r_sta_vld <= 1'b0;
      end
   end

   // TX state register.
   always_ff @(posedge CLK_IN) begin
      if (RST_IN) begin
         r_tx_st <= ST_IDLE;
      end else begin
         r_tx_st <= w_tx_nxt;
      end
   end

   // TX next state; losing run aborts a pair without resending it.
   always_comb begin
      w_tx_nxt = ST_IDLE;
      if (!r_run_q) begin
         w_tx_nxt = ST_IDLE;
      end else begin
         case (r_tx_st)
            ST_IDLE: w_tx_nxt = w_last ? ST_HI : ST_IDLE;
            ST_HI:   w_tx_nxt = ST_LO;
            ST_LO:   w_tx_nxt = w_last ? ST_HI : ST_IDLE;
            default: w_tx_nxt = ST_IDLE;
         endcase
      end
   end

   // VPS outputs registered from the next state so they line up with r_tx_st.
   always_ff @(posedge CLK_IN) begin
      if (RST_IN) begin
         r_vps_idx <= 4'd0;
         r_vps_dat <= 16'd0;
         r_vps_vld <= 1'b0;
      end else begin
         case (w_tx_nxt)
            ST_HI: begin
               r_vps_vld <= 1'b1;
               r_vps_idx <= LP_IDX_HI;
               r_vps_dat <= w_pulse_nxt[31:16];
            end
            ST_LO: begin
               // r_sta_cnt already holds the result captured one cycle earlier.
               r_vps_vld <= 1'b1;
               r_vps_idx <= LP_IDX_LO;
               r_vps_dat <= r_sta_cnt[15:0];
            end
            default: begin
               r_vps_vld <= 1'b0;
            end
         endcase
      end
   end

   assign STA_CNT_OUT = r_sta_cnt;
   assign STA_OF_OUT  = r_sta_of;
   assign STA_VLD_OUT = r_sta_vld;
   assign VPS_IDX_OUT = r_vps_idx;
   assign VPS_DAT_OUT = r_vps_dat;
   assign VPS_VLD_OUT = r_vps_vld;

endmodule

// File: tb/tb_prt_vtb_cm.sv
// -----------------------------------------------------------------------------
// tb_prt_vtb_cm - scoreboard bench for prt_vtb_cm
//
// A reference model turns each cycle's inputs into whole-window pulse sums and
// queues the expected status result and VPS words, stamped with the cycle on
// which they must appear. A monitor on the falling edge pops and compares
// whenever the DUT raises a valid, and checks held values in between.
// -----------------------------------------------------------------------------
module tb_prt_vtb_cm;

   localparam int unsigned P = 2;
   localparam longint MAXC = 64'h0000_0000_FFFF_FFFF;

   logic        CLK_IN = 1'b0;
   logic        RST_IN;
   logic        CTL_RUN_IN;
   logic [31:0] CTL_GATE_IN;
   logic        CKE_IN;
   logic [31:0] STA_CNT_OUT;
   logic        STA_OF_OUT;
   logic        STA_VLD_OUT;
   logic [3:0]  VPS_IDX_OUT;
   logic [15:0] VPS_DAT_OUT;
   logic        VPS_VLD_OUT;

   prt_vtb_cm #(.P_VPS_IDX(P)) dut (
      .CLK_IN      (CLK_IN),
      .RST_IN      (RST_IN),
      .CTL_RUN_IN  (CTL_RUN_IN),
      .CTL_GATE_IN (CTL_GATE_IN),
      .CKE_IN      (CKE_IN),
      .STA_CNT_OUT (STA_CNT_OUT),
      .STA_OF_OUT  (STA_OF_OUT),
      .STA_VLD_OUT (STA_VLD_OUT),
      .VPS_IDX_OUT (VPS_IDX_OUT),
      .VPS_DAT_OUT (VPS_DAT_OUT),
      .VPS_VLD_OUT (VPS_VLD_OUT)
   );

   always #5 CLK_IN = ~CLK_IN;

   typedef struct {
      int          cyc;
      logic [31:0] cnt;
      logic        of;
   } sta_t;

   typedef struct {
      int          cyc;
      logic [3:0]  idx;
      logic [15:0] dat;
   } vps_t;

   sta_t sta_q[$];
   vps_t vps_q[$];

   int n_chk = 0;
   int n_err = 0;
   int m_cyc = 0;

   logic [3:0]  idx_hi;
   logic [3:0]  idx_lo;
   logic [31:0] m_last_cnt = 32'd0;
   logic        m_last_of  = 1'b0;
   logic [3:0]  m_last_idx = 4'd0;
   logic [15:0] m_last_dat = 16'd0;

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", name, m_cyc, act, exp);
      end
   endtask

   // Reference model: run is seen one cycle late; a window is G cycles of
   // summed CKE_IN, the result is clipped at 2^32-1 and the pair follows.
   initial begin : model
      bit          run_q    = 1'b0;
      bit          in_win   = 1'b0;
      bit          pend_lo  = 1'b0;
      longint      sum      = 0;
      longint      left     = 0;
      longint      g;
      logic [31:0] res      = 32'd0;
      logic        of;
      idx_hi = 4'(P);
      idx_lo = 4'((P + 1) % 16);
      forever begin
         @(posedge CLK_IN);
         m_cyc++;
         if (RST_IN) begin
            run_q = 1'b0; in_win = 1'b0; pend_lo = 1'b0; sum = 0;
            m_last_cnt = 32'd0; m_last_of = 1'b0;
            m_last_idx = 4'd0;  m_last_dat = 16'd0;
         end else begin
            if (pend_lo && run_q) begin
               vps_q.push_back('{m_cyc, idx_lo, res[15:0]});
               m_last_idx = idx_lo; m_last_dat = res[15:0];
            end
            pend_lo = 1'b0;
            if (!run_q) begin
               in_win = 1'b0;
            end else if (!in_win) begin
               g = longint'(CTL_GATE_IN);
               if (g != 0) begin
                  in_win = 1'b1;
                  left   = ((g == 1) ? 2 : g) - 1;
                  sum    = longint'(CKE_IN);
               end
            end else begin
               sum  = sum + longint'(CKE_IN);
               left = left - 1;
               if (left == 0) begin
                  of  = (sum > MAXC);
                  res = of ? 32'hFFFF_FFFF : sum[31:0];
                  sta_q.push_back('{m_cyc, res, of});
                  vps_q.push_back('{m_cyc, idx_hi, res[31:16]});
                  m_last_cnt = res; m_last_of = of;
                  m_last_idx = idx_hi; m_last_dat = res[31:16];
                  pend_lo = 1'b1;
                  in_win  = 1'b0;
               end
            end
            run_q = CTL_RUN_IN;
         end
      end
   end

   // Monitor: compare on valids, flag late/unexpected items, check held values.
   initial begin : monitor
      sta_t s;
      vps_t v;
      forever begin
         @(negedge CLK_IN);
         while (sta_q.size() > 0 && sta_q[0].cyc < m_cyc) begin
            s = sta_q.pop_front();
            check("sta_missing_at_cycle", 0, longint'(s.cyc));
         end
         while (vps_q.size() > 0 && vps_q[0].cyc < m_cyc) begin
            v = vps_q.pop_front();
            check("vps_missing_at_cycle", 0, longint'(v.cyc));
         end
         if (STA_VLD_OUT) begin
            if (sta_q.size() == 0) begin
               check("sta_unexpected_vld", 1, 0);
            end else begin
               s = sta_q.pop_front();
               check("sta_cycle", longint'(m_cyc), longint'(s.cyc));
               check("sta_cnt", longint'(STA_CNT_OUT), longint'(s.cnt));
               check("sta_of", longint'(STA_OF_OUT), longint'(s.of));
            end
         end else begin
            check("sta_cnt_hold", longint'(STA_CNT_OUT), longint'(m_last_cnt));
            check("sta_of_hold", longint'(STA_OF_OUT), longint'(m_last_of));
         end
         if (VPS_VLD_OUT) begin
            if (vps_q.size() == 0) begin
               check("vps_unexpected_vld", 1, 0);
            end else begin
               v = vps_q.pop_front();
               check("vps_cycle", longint'(m_cyc), longint'(v.cyc));
               check("vps_idx", longint'(VPS_IDX_OUT), longint'(v.idx));
               check("vps_dat", longint'(VPS_DAT_OUT), longint'(v.dat));
            end
         end else begin
            check("vps_idx_hold", longint'(VPS_IDX_OUT), longint'(m_last_idx));
            check("vps_dat_hold", longint'(VPS_DAT_OUT), longint'(m_last_dat));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge CLK_IN);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_sta_cnt"}, longint'(STA_CNT_OUT), 0);
      check({tag, "_sta_of"},  longint'(STA_OF_OUT), 0);
      check({tag, "_sta_vld"}, longint'(STA_VLD_OUT), 0);
      check({tag, "_vps_idx"}, longint'(VPS_IDX_OUT), 0);
      check({tag, "_vps_dat"}, longint'(VPS_DAT_OUT), 0);
      check({tag, "_vps_vld"}, longint'(VPS_VLD_OUT), 0);
   endtask

   // Stimulus
   initial begin : stim
      RST_IN = 1'b1; CTL_RUN_IN = 1'b0; CTL_GATE_IN = 32'd0; CKE_IN = 1'b0;
      step(3);
      check_all_zero("reset");
      RST_IN = 1'b0;
      step(2);

      // G=100, constant enable
      CTL_GATE_IN = 32'd100; CKE_IN = 1'b1; CTL_RUN_IN = 1'b1;
      step(320);
      CTL_RUN_IN = 1'b0; step(4);

      // G=1000, enable toggling
      CTL_GATE_IN = 32'd1000; CTL_RUN_IN = 1'b1;
      for (int i = 0; i < 2100; i++) begin
         CKE_IN = 1'(i % 2 == 0);
         step(1);
      end
      CTL_RUN_IN = 1'b0; step(4);

      // G=0 idles, then G=10 opens a window immediately
      CTL_GATE_IN = 32'd0; CTL_RUN_IN = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         CKE_IN = 1'($urandom % 2);
         step(1);
      end
      CKE_IN = 1'b1; CTL_GATE_IN = 32'd10;
      step(40);
      CTL_RUN_IN = 1'b0; step(4);

      // G=200, changed to 50 mid-window
      CTL_GATE_IN = 32'd200; CTL_RUN_IN = 1'b1;
      step(100);
      CTL_GATE_IN = 32'd50;
      step(300);
      // G=1 behaves as 2
      CTL_GATE_IN = 32'd1;
      step(12);
      CTL_RUN_IN = 1'b0; step(4);

      // Reset mid-window after one result, then a full window again
      CTL_GATE_IN = 32'd50; CTL_RUN_IN = 1'b1;
      step(73);
      RST_IN = 1'b1;
      step(1);
      check_all_zero("midrst");
      RST_IN = 1'b0;
      step(120);
      CTL_RUN_IN = 1'b0; step(4);

      // Abort during HI: run drops so the capture edge sees run low next
      CTL_GATE_IN = 32'd300; CTL_RUN_IN = 1'b1;
      step(1);
      step(299);
      CTL_RUN_IN = 1'b0;
      step(6);

      // Randomized gates, enables, run drops and occasional resets
      CTL_RUN_IN = 1'b1; CTL_GATE_IN = 32'($urandom_range(0, 40));
      for (int i = 0; i < 3000; i++) begin
         CKE_IN = 1'($urandom % 4 != 0);
         if ($urandom % 300 == 0) CTL_GATE_IN = 32'($urandom_range(0, 40));
         if ($urandom % 500 == 0) CTL_RUN_IN = ~CTL_RUN_IN;
         else if (!CTL_RUN_IN && ($urandom % 8 == 0)) CTL_RUN_IN = 1'b1;
         RST_IN = 1'($urandom % 1500 == 0);
         step(1);
      end
      RST_IN = 1'b0; CTL_RUN_IN = 1'b0; step(4);

      // G=70000 with constant enable: result 0x00011170
      CTL_GATE_IN = 32'd70000; CKE_IN = 1'b1; CTL_RUN_IN = 1'b1;
      step(70010);
      CTL_RUN_IN = 1'b0;
      step(10);

      check("sta_queue_drained", longint'(sta_q.size()), 0);
      check("vps_queue_drained", longint'(vps_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
